// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decodes fetched instruction words into opcode, register
// indices and raw immediate fields behind a 2-entry skid buffer.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_instr/in_pc
// from fetch; flush discards all held beats; out_valid/out_ready handshake
// with execute; out_pc, out_cls, out_opcode, out_rd, out_rs, out_rt,
// out_cond, out_imm15, out_imm19, out_off23, out_illegal carry the beat.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (flag reserved encodings).
module instr_decode_stage #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      out_cls,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [2:0]      out_cond,
    output logic [14:0]     out_imm15,
    output logic [18:0]     out_imm19,
    output logic [22:0]     out_off23,
    output logic            out_illegal
);

    if (INSTR_W != 32) begin : g_bad_width
        $error("instr_decode_stage: only INSTR_W = 32 is supported");
    end

    localparam logic [1:0] CLS_AR  = 2'b00;
    localparam logic [1:0] CLS_ART = 2'b01;
    localparam logic [1:0] CLS_L   = 2'b10;
    localparam logic [1:0] CLS_J   = 2'b11;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [1:0]      cls;
        logic [5:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [2:0]      cond;
        logic [14:0]     imm15;
        logic [18:0]     imm19;
        logic [22:0]     off23;
        logic            illegal;
    } beat_t;

    function automatic beat_t decode(
        input logic [31:0]     instr,
        input logic [PC_W-1:0] pc
    );
        beat_t b;
        b         = '0;
        b.pc      = pc;
        b.cls     = instr[31:30];
        b.opcode  = instr[31:26];
        b.rd      = instr[25:21];
        b.rs      = instr[20:16];
        b.rt      = instr[15:11];
        case (b.cls)
            CLS_AR:  ;
            CLS_ART: b.imm19 = instr[18:0];
            CLS_L:   b.imm15 = instr[14:0];
            CLS_J: begin
                b.rd    = '0;
                b.rs    = '0;
                b.cond  = instr[25:23];
                b.off23 = instr[22:0];
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        b.illegal = (b.opcode == 6'b001111)
                 || (b.opcode == 6'b011111)
                 || (b.cls == CLS_J && instr[25:23] == 3'b111);
        // Illegal beats still flow so execute can trap, but carry no immediate.
        if (b.illegal) begin
            b.imm15 = '0;
            b.imm19 = '0;
            b.off23 = '0;
        end
`else
        b.illegal = 1'b0;
`endif
        return b;
    endfunction

    beat_t main_q;
    beat_t skid_q;
    beat_t in_beat;
    logic  main_valid;
    logic  skid_valid;
    logic  accept;
    logic  drain;

    assign in_beat = decode(in_instr, in_pc);
    assign accept  = in_valid && !skid_valid;
    assign drain   = main_valid && out_ready;

    // Main register drives the outputs; the skid register only catches a
    // beat accepted while main is stalled, so in_ready is a pure flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= in_beat;
                end
            end
        end else if (accept) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign in_ready    = !skid_valid;
    assign out_valid   = main_valid;
    assign out_pc      = main_q.pc;
    assign out_cls     = main_q.cls;
    assign out_opcode  = main_q.opcode;
    assign out_rd      = main_q.rd;
    assign out_rs      = main_q.rs;
    assign out_rt      = main_q.rt;
    assign out_cond    = main_q.cond;
    assign out_imm15   = main_q.imm15;
    assign out_imm19   = main_q.imm19;
    assign out_off23   = main_q.off23;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: FIFO-model scoreboard bench for instr_decode_stage.
// Directed scenarios plus randomized traffic, checked every cycle.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [1:0]  out_cls;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [2:0]  out_cond;
    logic [14:0] out_imm15;
    logic [18:0] out_imm19;
    logic [22:0] out_off23;
    logic        out_illegal;

    always #5 clk = ~clk;

    instr_decode_stage #(.PC_W(32), .INSTR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_cls(out_cls), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_cond(out_cond), .out_imm15(out_imm15),
        .out_imm19(out_imm19), .out_off23(out_off23),
        .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    beat_t       model_q[$];
    logic [31:0] drained[$];
    int          tests = 0;
    int          fails = 0;

    logic [115:0] dut_fields;
    assign dut_fields = {out_pc, out_cls, out_opcode, out_rd, out_rs, out_rt,
                         out_cond, out_imm15, out_imm19, out_off23, out_illegal};

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    function automatic logic [115:0] ref_decode(logic [31:0] pc, logic [31:0] i);
        logic [1:0]  cls;
        logic [4:0]  rd, rs;
        logic [2:0]  cond;
        logic [14:0] imm15;
        logic [18:0] imm19;
        logic [22:0] off23;
        logic        ill;
        cls   = i[31:30];
        rd    = (cls == 2'd3) ? 5'd0 : i[25:21];
        rs    = (cls == 2'd3) ? 5'd0 : i[20:16];
        cond  = (cls == 2'd3) ? i[25:23] : 3'd0;
        imm15 = (cls == 2'd2) ? i[14:0] : 15'd0;
        imm19 = (cls == 2'd1) ? i[18:0] : 19'd0;
        off23 = (cls == 2'd3) ? i[22:0] : 23'd0;
        ill   = TRAP && (i[31:26] == 6'd15 || i[31:26] == 6'd31
                         || (cls == 2'd3 && i[25:23] == 3'd7));
        if (ill) begin
            imm15 = '0;
            imm19 = '0;
            off23 = '0;
        end
        return {pc, cls, i[31:26], rd, rs, i[15:11], cond, imm15, imm19, off23, ill};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a 2-deep FIFO updated on the clock from the handshake rules.
    always @(posedge clk) begin
        automatic int n;
        automatic bit acc;
        automatic bit drn;
        if (rst_n) begin
            n   = model_q.size();
            acc = in_valid && (n < 2);
            drn = (n > 0) && out_ready;
            if (flush) begin
                model_q.delete();
            end else begin
                if (drn) begin
                    drained.push_back(model_q[0].pc);
                    void'(model_q.pop_front());
                end
                if (acc) model_q.push_back('{in_pc, in_instr});
            end
        end
    end

    always @(negedge rst_n) model_q.delete();

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("out_valid", 128'(out_valid), 128'(model_q.size() > 0));
        check("in_ready", 128'(in_ready), 128'(model_q.size() < 2));
        if (model_q.size() > 0)
            check("fields", 128'(dut_fields),
                  128'(ref_decode(model_q[0].pc, model_q[0].instr)));
        else if (!rst_n)
            check("reset_fields", 128'(dut_fields), 128'd0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(bit v, logic [31:0] ins, logic [31:0] pc, bit rdy, bit fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        set_in(0, 32'h0, 32'h0, 0, 0);
        tick();
        tick();
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_pc", 128'(out_pc), 128'd0);
        rst_n = 1'b1;
        tick();

        // J decode
        set_in(1, 32'hC07FFFFF, 32'h100, 1, 0);
        tick();
        check("j_valid", 128'(out_valid), 128'd1);
        check("j_cls", 128'(out_cls), 128'd3);
        check("j_off23", 128'(out_off23), 128'h7FFFFF);
        check("j_cond", 128'(out_cond), 128'd0);
        check("j_imm15", 128'(out_imm15), 128'd0);
        check("j_imm19", 128'(out_imm19), 128'd0);
        check("j_pc", 128'(out_pc), 128'h100);

        // L decode
        set_in(1, 32'h80644000, 32'h104, 1, 0);
        tick();
        check("l_cls", 128'(out_cls), 128'd2);
        check("l_rd", 128'(out_rd), 128'd3);
        check("l_rs", 128'(out_rs), 128'd4);
        check("l_imm15", 128'(out_imm15), 128'h4000);
        check("l_off23", 128'(out_off23), 128'd0);
        set_in(0, 32'h0, 32'h0, 1, 0);
        tick();

        // Backpressure: FULL, then drain in order
        drained.delete();
        set_in(1, $urandom, 32'h0, 0, 0);
        tick();
        set_in(1, $urandom, 32'h4, 0, 0);
        tick();
        set_in(1, $urandom, 32'h8, 0, 0);
        tick();
        check("bp_in_ready", 128'(in_ready), 128'd0);
        check("bp_head_pc", 128'(out_pc), 128'h0);
        tick();
        check("bp_hold_pc", 128'(out_pc), 128'h0);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bp_count", 128'(drained.size()), 128'd3);
        if (drained.size() == 3) begin
            check("bp_order0", 128'(drained[0]), 128'h0);
            check("bp_order1", 128'(drained[1]), 128'h4);
            check("bp_order2", 128'(drained[2]), 128'h8);
        end

        // Flush in FULL with a beat offered
        drained.delete();
        set_in(1, $urandom, 32'h40, 0, 0);
        tick();
        set_in(1, $urandom, 32'h44, 0, 0);
        tick();
        set_in(1, $urandom, 32'h48, 0, 1);
        tick();
        check("fl_out_valid", 128'(out_valid), 128'd0);
        check("fl_in_ready", 128'(in_ready), 128'd1);
        // Flush while an accept happens from EMPTY
        set_in(1, $urandom, 32'h4C, 1, 1);
        tick();
        check("fl_acc_valid", 128'(out_valid), 128'd0);
        set_in(0, 32'h0, 32'h0, 1, 0);
        tick();
        tick();
        check("fl_no_output", 128'(drained.size()), 128'd0);

        // Async reset while FULL
        set_in(1, $urandom, 32'h60, 0, 0);
        tick();
        set_in(1, $urandom, 32'h64, 0, 0);
        tick();
        set_in(0, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 128'(out_valid), 128'd0);
        check("ar_in_ready", 128'(in_ready), 128'd1);
        tick();
        tick();
        rst_n = 1'b1;
        drained.delete();
        set_in(1, $urandom, 32'h20, 1, 0);
        tick();
        check("ar_first_pc", 128'(out_pc), 128'h20);
        set_in(0, 32'h0, 32'h0, 1, 0);
        tick();
        tick();
        check("ar_count", 128'(drained.size()), 128'd1);
        if (drained.size() == 1) check("ar_only", 128'(drained[0]), 128'h20);

        // Reserved encodings
        set_in(1, 32'h3C000000, 32'h80, 1, 0);
        tick();
        check("ill_op0f", 128'(out_illegal), 128'(TRAP));
        check("ill_imm", 128'({out_imm15, out_imm19, out_off23}), 128'd0);
        set_in(1, 32'hC3812345, 32'h84, 1, 0);
        tick();
        check("ill_jcond", 128'(out_illegal), 128'(TRAP));
        check("ill_joff", 128'(out_off23), TRAP ? 128'd0 : 128'h012345);
        set_in(0, 32'h0, 32'h0, 1, 0);
        tick();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = $urandom;
            if ($urandom_range(7) == 0) r[31:26] = $urandom_range(1) ? 6'h0F : 6'h1F;
            if ($urandom_range(7) == 0) r[31:23] = 9'h1FF;
            set_in($urandom_range(3) != 0, r, $urandom,
                   $urandom_range(2) != 0, $urandom_range(39) == 0);
            tick();
        end
        set_in(0, 32'h0, 32'h0, 1, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
